// File: rtl/lsu_ctrl.sv
// Load/store controller: byte/half/word accesses to a word-wide data memory,
// read-modify-write for sub-word stores, sign/zero extension for loads.
module lsu_ctrl #(
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic               i_req_we,
   input  logic [1:0]         i_req_size,
   input  logic               i_req_unsigned,
   input  logic [A_WIDTH-1:0] i_req_addr,
   input  logic [D_WIDTH-1:0] i_req_wdata,
   output logic               o_resp_valid,
   output logic [D_WIDTH-1:0] o_resp_rdata,
   output logic               o_resp_err,
   output logic               o_mem_we,
   output logic [A_WIDTH-1:0] o_mem_w_addr,
   output logic [D_WIDTH-1:0] o_mem_w_data,
   output logic               o_mem_re,
   output logic [A_WIDTH-1:0] o_mem_r_addr,
   input  logic [D_WIDTH-1:0] i_mem_r_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RMW_RD,
      S_WRITE,
      S_RESP
   } state_t;

   state_t r_state;
   state_t w_next;

   logic               r_we;
   logic [1:0]         r_size;
   logic               r_uns;
   logic [A_WIDTH-1:0] r_addr;
   logic [D_WIDTH-1:0] r_wdata;
   logic [D_WIDTH-1:0] r_buf;
   logic [D_WIDTH-1:0] r_rdata;
   logic               r_err;

   logic               w_hs;
   logic               w_misal;
   logic [4:0]         w_shift;
   logic [D_WIDTH-1:0] w_lane;
   logic [D_WIDTH-1:0] w_ext;
   logic [D_WIDTH-1:0] w_mask;
   logic [D_WIDTH-1:0] w_ins;
   logic [D_WIDTH-1:0] w_merge;
   logic [A_WIDTH-1:0] w_waddr;

   assign w_hs    = i_req_valid & o_req_ready;
   assign w_misal = (i_req_size == 2'b11)
                  | ((i_req_size == 2'b01) & i_req_addr[0])
                  | ((i_req_size == 2'b10) & (i_req_addr[1:0] != 2'b00));

   assign w_waddr = {r_addr[A_WIDTH-1:2], 2'b00};
   assign w_shift = {r_addr[1:0], 3'b000};

   // Bring the addressed lane down to bit 0, then extend by size.
   assign w_lane = i_mem_r_data >> w_shift;

   always_comb begin
      w_ext = w_lane;
      case (r_size)
         2'b00: w_ext = r_uns ? {24'h0, w_lane[7:0]}
                              : {{24{w_lane[7]}}, w_lane[7:0]};
         2'b01: w_ext = r_uns ? {16'h0, w_lane[15:0]}
                              : {{16{w_lane[15]}}, w_lane[15:0]};
         default: w_ext = w_lane;
      endcase
   end

   assign w_mask  = (r_size == 2'b00) ? (32'h0000_00FF << w_shift)
                                      : (32'h0000_FFFF << w_shift);
   assign w_ins   = r_wdata << w_shift;
   assign w_merge = (r_buf & ~w_mask) | (w_ins & w_mask);

   assign o_mem_w_addr = w_waddr;
   assign o_mem_r_addr = w_waddr;
   assign o_mem_w_data = (r_size == 2'b10) ? r_wdata : w_merge;
   assign o_resp_rdata = r_rdata;
   assign o_resp_err   = r_err;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      o_req_ready  = 1'b0;
      o_mem_re     = 1'b0;
      o_mem_we     = 1'b0;
      o_resp_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_req_ready = 1'b1;
            if (w_hs) begin
               if (w_misal)                   w_next = S_RESP;
               else if (!i_req_we)            w_next = S_LOAD;
               else if (i_req_size == 2'b10)  w_next = S_WRITE;
               else                           w_next = S_RMW_RD;
            end
         end
         S_LOAD: begin
            o_mem_re = 1'b1;
            w_next   = S_RESP;
         end
         S_RMW_RD: begin
            o_mem_re = 1'b1;
            w_next   = S_WRITE;
         end
         S_WRITE: begin
            o_mem_we = 1'b1;
            w_next   = S_RESP;
         end
         S_RESP: begin
            o_resp_valid = 1'b1;
            w_next       = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_we    <= 1'b0;
         r_size  <= 2'b00;
         r_uns   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_buf   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_hs) begin
            r_we    <= i_req_we;
            r_size  <= i_req_size;
            r_uns   <= i_req_unsigned;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            if (w_misal) begin
               r_err   <= 1'b1;
               r_rdata <= '0;
            end
         end
         if (r_state == S_LOAD) begin
            r_rdata <= w_ext;
            r_err   <= 1'b0;
         end
         if (r_state == S_RMW_RD) r_buf <= i_mem_r_data;
         if (r_state == S_WRITE) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a small behavioural word memory.
module tb_lsu_ctrl;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_uns;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_w_addr;
   logic [31:0] mem_w_data;
   logic        mem_re;
   logic [31:0] mem_r_addr;
   logic [31:0] mem_r_data;

   logic [31:0] mem [0:63];

   exp_t q [$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   we_cnt = 0;
   int   re_cnt = 0;
   int   rv_cnt = 0;
   logic [31:0] last_waddr = '0;
   logic [31:0] last_wdata = '0;

   lsu_ctrl dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_we       (req_we),
      .i_req_size     (req_size),
      .i_req_unsigned (req_uns),
      .i_req_addr     (req_addr),
      .i_req_wdata    (req_wdata),
      .o_resp_valid   (resp_valid),
      .o_resp_rdata   (resp_rdata),
      .o_resp_err     (resp_err),
      .o_mem_we       (mem_we),
      .o_mem_w_addr   (mem_w_addr),
      .o_mem_w_data   (mem_w_data),
      .o_mem_re       (mem_re),
      .o_mem_r_addr   (mem_r_addr),
      .i_mem_r_data   (mem_r_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_r_data = mem[mem_r_addr[7:2]];

   always @(posedge clk) begin
      if (mem_we) mem[mem_w_addr[7:2]] <= mem_w_data;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Monitor: strobe bookkeeping and scoreboard pops on each response.
   always @(negedge clk) begin
      if (mem_we) begin
         we_cnt++;
         last_waddr = mem_w_addr;
         last_wdata = mem_w_data;
      end
      if (mem_re) re_cnt++;
      if (resp_valid) begin
         rv_cnt++;
         if (q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
         end
      end
   end

   task automatic do_req(input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_re,
                         input int exp_we, input logic [31:0] exp_waddr,
                         input logic [31:0] exp_wdata);
      int re0, we0, k;
      exp_t e;
      int guard;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("req_ready", {31'd0, req_ready}, 32'd1);
      re0 = re_cnt;
      we0 = we_cnt;
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_uns   = uns;
      req_addr  = addr;
      req_wdata = wdata;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!resp_valid && k < 10);
      chk("latency", k, exp_lat);
      chk("mem_re_cycles", re_cnt - re0, exp_re);
      chk("mem_we_pulses", we_cnt - we0, exp_we);
      if (exp_we != 0) begin
         chk("mem_w_addr", last_waddr, exp_waddr);
         chk("mem_w_data", last_wdata, exp_wdata);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[8]  = 32'h1122_3344;
      mem[16] = 32'h5566_7788;
      rst       = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_size  = 2'b00;
      req_uns   = 1'b0;
      req_addr  = '0;
      req_wdata = '0;

      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_ready", {31'd0, req_ready}, 32'd1);
         chk("rst_valid", {31'd0, resp_valid}, 32'd0);
         chk("rst_err", {31'd0, resp_err}, 32'd0);
         chk("rst_rdata", resp_rdata, 32'd0);
         chk("rst_re", {31'd0, mem_re}, 32'd0);
      end
      chk("rst_we_held", we_cnt, 32'd0);
      rst = 1'b0;

      do_req(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 2, 0, 1,
             32'h10, 32'hDEAD_BEEF);
      do_req(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 2, 1, 0,
             32'h0, 32'h0);
      do_req(0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFF_FFDE, 0, 2, 1, 0,
             32'h0, 32'h0);
      do_req(0, 2'b01, 1, 32'h12, 32'h0, 32'h0000_DEAD, 0, 2, 1, 0,
             32'h0, 32'h0);
      do_req(0, 2'b00, 1, 32'h10, 32'h0, 32'h0000_00EF, 0, 2, 1, 0,
             32'h0, 32'h0);
      do_req(1, 2'b00, 0, 32'h21, 32'h0000_00AB, 32'h0, 0, 3, 1, 1,
             32'h20, 32'h1122_AB44);
      do_req(1, 2'b01, 0, 32'h22, 32'h1234_CAFE, 32'h0, 0, 3, 1, 1,
             32'h20, 32'hCAFE_AB44);
      do_req(0, 2'b01, 0, 32'h22, 32'h0, 32'hFFFF_CAFE, 0, 2, 1, 0,
             32'h0, 32'h0);
      do_req(0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFE_AB44, 0, 2, 1, 0,
             32'h0, 32'h0);
      do_req(0, 2'b01, 0, 32'h31, 32'h0, 32'h0, 1, 1, 0, 0,
             32'h0, 32'h0);
      do_req(1, 2'b10, 0, 32'h32, 32'h5555_AAAA, 32'h0, 1, 1, 0, 0,
             32'h0, 32'h0);
      do_req(0, 2'b11, 0, 32'h30, 32'h0, 32'h0, 1, 1, 0, 0,
             32'h0, 32'h0);
      do_req(0, 2'b00, 0, 32'h30, 32'h0, 32'h0, 0, 2, 1, 0,
             32'h0, 32'h0);

      // Reset while the byte store to 0x40 sits in RMW_RD.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b00;
      req_uns   = 1'b0;
      req_addr  = 32'h41;
      req_wdata = 32'h0000_0099;
      @(posedge clk);
      #2;
      req_valid = 1'b0;
      chk("rmw_pending_re", {31'd0, mem_re}, 32'd1);
      rst = 1'b1;
      begin
         int rv0, we0;
         rv0 = rv_cnt;
         we0 = we_cnt;
         repeat (3) @(negedge clk);
         rst = 1'b0;
         repeat (3) @(negedge clk);
         chk("rst_rmw_mem", mem[16], 32'h5566_7788);
         chk("rst_rmw_no_resp", rv_cnt - rv0, 32'd0);
         chk("rst_rmw_no_we", we_cnt - we0, 32'd0);
      end
      do_req(0, 2'b10, 0, 32'h40, 32'h0, 32'h5566_7788, 0, 2, 1, 0,
             32'h0, 32'h0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
